// File: rtl/adder_share_scheduler_pkg.sv
// Shared definitions for the single-adder (A+B)+(C+D) scheduler: state encoding
// and the position of each operand inside a packed operand bus.
package adder_share_scheduler_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE      = 3'd0,
        STATE_SUM_LEFT  = 3'd1,
        STATE_SUM_RIGHT = 3'd2,
        STATE_SUM_FINAL = 3'd3,
        STATE_DONE      = 3'd4
    } schedState_t;

    // Slot index of each operand; slot k occupies bits [(k+1)*N-1 : k*N].
    localparam int OPERAND_A = 0;
    localparam int OPERAND_B = 1;
    localparam int OPERAND_C = 2;
    localparam int OPERAND_D = 3;
    localparam int OPERAND_COUNT = 4;

endpackage

// File: rtl/adder_share_scheduler_shared_adder_stage.sv
// Combinational numberOfBits-wide adder; the carry-out is kept separate from
// the wrapped sum so the scheduler can accumulate it as an overflow flag.
module shared_adder_stage #(
    parameter int numberOfBits = 8
) (
    input  logic [numberOfBits-1:0] addendA,
    input  logic [numberOfBits-1:0] addendB,
    output logic [numberOfBits-1:0] sum,
    output logic                    carryOut
);

    assign {carryOut, sum} = {1'b0, addendA} + {1'b0, addendB};

endmodule

// File: rtl/adder_share_scheduler.sv
// Two requesters share one adder: each transaction computes (A+B)+(C+D) over
// three cycles, with round-robin arbitration and a registered handshake.
module adder_share_scheduler
    import adder_share_scheduler_pkg::*;
#(
    parameter int numberOfBits = 8
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    request0,
    input  logic                                    request1,
    input  logic [OPERAND_COUNT*numberOfBits-1:0]   operands0,
    input  logic [OPERAND_COUNT*numberOfBits-1:0]   operands1,
    output logic [1:0]                              grant,
    output logic                                    busy,
    output logic                                    resultValid,
    output logic                                    resultOwner,
    output logic [numberOfBits-1:0]                 result,
    output logic                                    overflow
);

    schedState_t                               state;
    logic [OPERAND_COUNT*numberOfBits-1:0]     operandReg;
    logic [numberOfBits-1:0]                   leftSum;
    logic [numberOfBits-1:0]                   rightSum;
    logic                                      owner;
    logic                                      lastServed;
    logic                                      carryAcc;

    logic [numberOfBits-1:0]                   operandA;
    logic [numberOfBits-1:0]                   operandB;
    logic [numberOfBits-1:0]                   operandC;
    logic [numberOfBits-1:0]                   operandD;

    logic [numberOfBits-1:0]                   addendA;
    logic [numberOfBits-1:0]                   addendB;
    logic [numberOfBits-1:0]                   adderSum;
    logic                                      adderCarry;

    logic                                      pickValid;
    logic                                      pickOwner;

    assign operandA = operandReg[OPERAND_A*numberOfBits +: numberOfBits];
    assign operandB = operandReg[OPERAND_B*numberOfBits +: numberOfBits];
    assign operandC = operandReg[OPERAND_C*numberOfBits +: numberOfBits];
    assign operandD = operandReg[OPERAND_D*numberOfBits +: numberOfBits];

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        pickValid = request0 | request1;
        pickOwner = 1'b0;
        if (request0 && request1) begin
            pickOwner = ~lastServed;
        end else if (request1) begin
            pickOwner = 1'b1;
        end
    end

    // The single adder's inputs are steered by which phase the FSM is in.
    always_comb begin
        addendA = '0;
        addendB = '0;
        unique case (state)
            STATE_SUM_LEFT: begin
                addendA = operandA;
                addendB = operandB;
            end
            STATE_SUM_RIGHT: begin
                addendA = operandC;
                addendB = operandD;
            end
            STATE_SUM_FINAL: begin
                addendA = leftSum;
                addendB = rightSum;
            end
            default: begin
                addendA = '0;
                addendB = '0;
            end
        endcase
    end

    shared_adder_stage #(
        .numberOfBits(numberOfBits)
    ) sharedAdder (
        .addendA (addendA),
        .addendB (addendB),
        .sum     (adderSum),
        .carryOut(adderCarry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= STATE_IDLE;
            operandReg  <= '0;
            leftSum     <= '0;
            rightSum    <= '0;
            owner       <= 1'b0;
            lastServed  <= 1'b1;
            carryAcc    <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            resultOwner <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                STATE_IDLE: begin
                    if (pickValid) begin
                        operandReg <= pickOwner ? operands1 : operands0;
                        owner      <= pickOwner;
                        lastServed <= pickOwner;
                        grant      <= pickOwner ? 2'b10 : 2'b01;
                        carryAcc   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= STATE_SUM_LEFT;
                    end
                end
                STATE_SUM_LEFT: begin
                    leftSum  <= adderSum;
                    carryAcc <= carryAcc | adderCarry;
                    grant    <= 2'b00;
                    state    <= STATE_SUM_RIGHT;
                end
                STATE_SUM_RIGHT: begin
                    rightSum <= adderSum;
                    carryAcc <= carryAcc | adderCarry;
                    state    <= STATE_SUM_FINAL;
                end
                STATE_SUM_FINAL: begin
                    result      <= adderSum;
                    overflow    <= carryAcc | adderCarry;
                    resultOwner <= owner;
                    resultValid <= 1'b1;
                    state       <= STATE_DONE;
                end
                STATE_DONE: begin
                    // Arbitration waits for IDLE so grants stay 5 cycles apart.
                    resultValid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= STATE_IDLE;
                end
                default: begin
                    grant       <= 2'b00;
                    busy        <= 1'b0;
                    resultValid <= 1'b0;
                    state       <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule
